npu_os_tile_ctrl: RTL and testbench
===================================

Name: npu_os_tile_ctrl

Overview:
- Sequencer for one output-stationary (OS) tile on the ARRAY_DIM x ARRAY_DIM systolic array inside the NPU.
- On a start pulse from the NPU_OP register decode, it latches the tile parameters from the NPU_PARA registers and runs four phases in order:
  - clear the PE accumulators;
  - stream K activation/weight vectors from the A and W buffers;
  - flush the array skew;
  - drain ARRAY_DIM result rows into the output buffer.
- It drives busy/done status back to the NPU_PARA status register, which the host polls.

Parameters:
- ARRAY_DIM, 16, systolic array rows/cols; legal range 2..64.
- BUF_AW, 10, buffer word-address width; all buffer addresses wrap modulo 2^BUF_AW.
- DWidth, 32, width of the parameter-register inputs.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle start pulse (write of 1 to NPU_OP_Start).
- a_base_addr_i  in  DWidth  A-buffer base word address; low BUF_AW bits used.
- a_num_rows_i  in  DWidth  K-1, where K is the reduction length; low 16 bits used.
- w_base_addr_i  in  DWidth  W-buffer base word address.
- w_num_cols_i  in  DWidth  K-1 as seen by the weight side; must equal a_num_rows_i.
- o_base_addr_i  in  DWidth  O-buffer base row address.
- abuf_ren_o  out  1  A-buffer read enable.
- abuf_raddr_o  out  BUF_AW  A-buffer read address.
- wbuf_ren_o  out  1  W-buffer read enable.
- wbuf_raddr_o  out  BUF_AW  W-buffer read address.
- pe_clear_o  out  1  synchronous clear of all PE accumulators.
- pe_valid_o  out  1  buffer read data valid into the skew/array edge.
- drain_en_o  out  1  array presents the row selected by drain_row_o.
- drain_row_o  out  $clog2(ARRAY_DIM)  row select.
- obuf_wen_o  out  1  O-buffer write enable.
- obuf_waddr_o  out  BUF_AW  O-buffer row address.
- busy_o  out  1  tile in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky error: start rejected because of a K mismatch.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-tile aborts immediately: no further buffer reads or writes, no done_o.
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. busy_o = (state != IDLE), registered.
- IDLE:
  - start_i=1 with a_num_rows_i[15:0]==w_num_cols_i[15:0]: latch all parameters, clear err_o, go to CLEAR.
  - start_i=1 with a mismatch: set err_o, stay in IDLE.
- CLEAR: pe_clear_o=1 for exactly 1 cycle, then FEED.
- FEED: lasts K cycles, with k counting 0..K-1.
  - abuf_ren_o = wbuf_ren_o = 1.
  - abuf_raddr_o = (a_base + k) mod 2^BUF_AW; wbuf_raddr_o = (w_base + k) mod 2^BUF_AW.
  - K=1 (num_rows=0) is legal and gives a single FEED cycle.
- pe_valid_o is abuf_ren_o delayed by one register stage (buffer read latency is 1 cycle), so it stays high during the first FLUSH cycle.
- FLUSH: 2*ARRAY_DIM-1 cycles (1 read-latency cycle + 2*(ARRAY_DIM-1) skew propagation). No enables are asserted.
- DRAIN: ARRAY_DIM cycles, with r counting 0..ARRAY_DIM-1.
  - drain_en_o = obuf_wen_o = 1, drain_row_o = r.
  - obuf_waddr_o = (o_base + r) mod 2^BUF_AW.
  - Write is same-cycle (the array row mux is combinational).
- DONE: done_o=1 for 1 cycle, then IDLE.
- Latency: done_o goes high 1 + K + (2*ARRAY_DIM-1) + ARRAY_DIM rising edges after the edge that sampled start_i. busy_o falls on the edge after done_o.
- start_i is ignored while busy_o=1: no restart, parameters unchanged, err_o unchanged.
- Parameter inputs are not sampled after the start edge; changes mid-tile have no effect.
- K counter is 16 bits, so the maximum K is 65536. The address adders wrap silently.
- When busy_o=0, all enables and address outputs are 0.

Decomposition:
- The shared package (alongside pkg_memorymap) holds:
  - the state enum os_ctrl_state_e;
  - PARA register offsets: STATUS=0x04, A_BASE=0x08, A_ROWS=0x0C, W_BASE=0x10, W_COLS=0x14, O_BASE=0x18;
  - the localparam FLUSH_CYCLES = 2*ARRAY_DIM-1.
- One sub-module: os_phase_counter, a loadable down-counter with a terminal-count flag. It is reused for the FEED, FLUSH and DRAIN lengths.

Test Plan:
1. DIM=16, a_base=0, w_base=0, o_base=0, rows=cols=15, start pulse.
   - 1 pe_clear cycle, then 16 reads at addresses 0..15.
   - obuf writes rows 0..15 at addresses 0..15.
   - done_o exactly 64 edges after start; busy_o low on the next edge.
2. rows=cols=0 (K=1).
   - Single FEED cycle, pe_valid_o high for 1 cycle.
   - done_o at 1+1+31+16 = 49 edges.
3. a_base=1020, rows=cols=7.
   - abuf_raddr sequence 1020,1021,1022,1023,0,1,2,3.
   - o_base=1018 gives obuf addresses wrapping 1018..1023,0..9.
4. rows=15, cols=14, start.
   - err_o=1, busy_o stays 0, no enables.
   - A following matched start clears err_o and runs normally.
5. A second start_i during FEED, plus changed a_base.
   - Ignored; address sequence and done timing identical to test 1.
6. rst_ni low for 2 cycles in the middle of DRAIN.
   - All outputs 0 asynchronously, no done_o.
   - After release, a fresh start completes with standard timing.

Source files
------------

// File: rtl/npu_os_tile_ctrl_pkg.sv
// Shared definitions for the output-stationary tile sequencer.
//   - os_ctrl_state_e : sequencer phase encoding
//   - PARA_*_OFS      : byte offsets of the NPU_PARA tile registers
//   - FLUSH_CYCLES    : skew flush length for the default 16x16 array
//   - flush_cycles()  : the same length for any array dimension
package npu_os_tile_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } os_ctrl_state_e;

    localparam logic [7:0] PARA_STATUS_OFS = 8'h04;
    localparam logic [7:0] PARA_A_BASE_OFS = 8'h08;
    localparam logic [7:0] PARA_A_ROWS_OFS = 8'h0C;
    localparam logic [7:0] PARA_W_BASE_OFS = 8'h10;
    localparam logic [7:0] PARA_W_COLS_OFS = 8'h14;
    localparam logic [7:0] PARA_O_BASE_OFS = 8'h18;

    // Width of the reduction-length counter (max K = 65536).
    localparam int K_CNT_W = 16;

    localparam int ARRAY_DIM_DEFAULT = 16;
    localparam int FLUSH_CYCLES      = 2 * ARRAY_DIM_DEFAULT - 1;

    // One read-latency cycle plus 2*(dim-1) cycles of skew propagation.
    function automatic int flush_cycles(input int dim);
        return 2 * dim - 1;
    endfunction

endpackage

// File: rtl/npu_os_tile_ctrl_os_phase_counter.sv
// Loadable down-counter that times one sequencer phase.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over dec_i)
//   load_val_i    : phase length minus one
//   dec_i         : count down by one; holds at zero
//   count_o       : current count
//   tc_o          : terminal count, high while the count is zero
module os_phase_counter #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             tc_o
);

    logic [Width-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (load_i) begin
            count_reg <= load_val_i;
        end else if (dec_i && (count_reg != '0)) begin
            count_reg <= count_reg - Width'(1);
        end
    end

    assign count_o = count_reg;
    assign tc_o    = (count_reg == '0);

endmodule

// File: rtl/npu_os_tile_ctrl.sv
// Sequencer for one output-stationary tile on the ARRAY_DIM x ARRAY_DIM
// systolic array: clear accumulators, feed K A/W vectors, flush the skew,
// drain ARRAY_DIM result rows into the output buffer, then pulse done.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   start_i                  : one-cycle start pulse (ignored while busy)
//   a/w/o_base_addr_i        : buffer base addresses (low BUF_AW bits used)
//   a_num_rows_i/w_num_cols_i: K-1 from both sides (low 16 bits, must match)
//   abuf_*/wbuf_*            : A/W buffer read enables and addresses
//   pe_clear_o, pe_valid_o   : accumulator clear, read data valid
//   drain_en_o, drain_row_o  : array row readout select
//   obuf_wen_o, obuf_waddr_o : output buffer row write
//   busy_o, done_o, err_o    : status (err_o is sticky K-mismatch)
module npu_os_tile_ctrl
    import npu_os_tile_ctrl_pkg::*;
#(
    parameter int ARRAY_DIM = 16,
    parameter int BUF_AW    = 10,
    parameter int DWidth    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [DWidth-1:0]            a_base_addr_i,
    input  logic [DWidth-1:0]            a_num_rows_i,
    input  logic [DWidth-1:0]            w_base_addr_i,
    input  logic [DWidth-1:0]            w_num_cols_i,
    input  logic [DWidth-1:0]            o_base_addr_i,
    output logic                         abuf_ren_o,
    output logic [BUF_AW-1:0]            abuf_raddr_o,
    output logic                         wbuf_ren_o,
    output logic [BUF_AW-1:0]            wbuf_raddr_o,
    output logic                         pe_clear_o,
    output logic                         pe_valid_o,
    output logic                         drain_en_o,
    output logic [$clog2(ARRAY_DIM)-1:0] drain_row_o,
    output logic                         obuf_wen_o,
    output logic [BUF_AW-1:0]            obuf_waddr_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int RowW = $clog2(ARRAY_DIM);
    localparam logic [K_CNT_W-1:0] FlushLoad = K_CNT_W'(flush_cycles(ARRAY_DIM) - 1);
    localparam logic [K_CNT_W-1:0] DrainLoad = K_CNT_W'(ARRAY_DIM - 1);

    os_ctrl_state_e       state_reg;
    logic [BUF_AW-1:0]    a_base_reg;
    logic [BUF_AW-1:0]    w_base_reg;
    logic [BUF_AW-1:0]    o_base_reg;
    logic [K_CNT_W-1:0]   k_m1_reg;

    logic                 cnt_load;
    logic [K_CNT_W-1:0]   cnt_load_val;
    logic                 cnt_dec;
    logic [K_CNT_W-1:0]   cnt_count;
    logic                 cnt_tc;

    logic k_match;
    assign k_match = (a_num_rows_i[K_CNT_W-1:0] == w_num_cols_i[K_CNT_W-1:0]);

    // A single counter times FEED, FLUSH and DRAIN back to back: it is
    // reloaded on the last cycle of the preceding phase, so each phase
    // starts with its full length already in place.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_reg)
            CLEAR: begin
                cnt_load     = 1'b1;
                cnt_load_val = k_m1_reg;
            end
            FEED: begin
                if (cnt_tc) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = FlushLoad;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_tc) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = DrainLoad;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRAIN:   cnt_dec = 1'b1;
            default: ;
        endcase
    end

    os_phase_counter #(
        .Width (K_CNT_W)
    ) u_phase_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_count),
        .tc_o       (cnt_tc)
    );

    // Outputs are registered: each transition writes the values that belong
    // to the state being entered, so they line up with state_reg.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            a_base_reg   <= '0;
            w_base_reg   <= '0;
            o_base_reg   <= '0;
            k_m1_reg     <= '0;
            abuf_ren_o   <= 1'b0;
            abuf_raddr_o <= '0;
            wbuf_ren_o   <= 1'b0;
            wbuf_raddr_o <= '0;
            pe_clear_o   <= 1'b0;
            pe_valid_o   <= 1'b0;
            drain_en_o   <= 1'b0;
            drain_row_o  <= '0;
            obuf_wen_o   <= 1'b0;
            obuf_waddr_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            pe_clear_o <= 1'b0;
            done_o     <= 1'b0;
            // Buffer read data arrives one cycle after the read enable.
            pe_valid_o <= abuf_ren_o;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        if (k_match) begin
                            a_base_reg <= a_base_addr_i[BUF_AW-1:0];
                            w_base_reg <= w_base_addr_i[BUF_AW-1:0];
                            o_base_reg <= o_base_addr_i[BUF_AW-1:0];
                            k_m1_reg   <= a_num_rows_i[K_CNT_W-1:0];
                            err_o      <= 1'b0;
                            busy_o     <= 1'b1;
                            pe_clear_o <= 1'b1;
                            state_reg  <= CLEAR;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    abuf_ren_o   <= 1'b1;
                    wbuf_ren_o   <= 1'b1;
                    abuf_raddr_o <= a_base_reg;
                    wbuf_raddr_o <= w_base_reg;
                    state_reg    <= FEED;
                end
                FEED: begin
                    if (cnt_tc) begin
                        abuf_ren_o   <= 1'b0;
                        wbuf_ren_o   <= 1'b0;
                        abuf_raddr_o <= '0;
                        wbuf_raddr_o <= '0;
                        state_reg    <= FLUSH;
                    end else begin
                        abuf_raddr_o <= abuf_raddr_o + BUF_AW'(1);
                        wbuf_raddr_o <= wbuf_raddr_o + BUF_AW'(1);
                    end
                end
                FLUSH: begin
                    if (cnt_tc) begin
                        drain_en_o   <= 1'b1;
                        obuf_wen_o   <= 1'b1;
                        drain_row_o  <= '0;
                        obuf_waddr_o <= o_base_reg;
                        state_reg    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_tc) begin
                        drain_en_o   <= 1'b0;
                        obuf_wen_o   <= 1'b0;
                        drain_row_o  <= '0;
                        obuf_waddr_o <= '0;
                        done_o       <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        drain_row_o  <= drain_row_o + RowW'(1);
                        obuf_waddr_o <= obuf_waddr_o + BUF_AW'(1);
                    end
                end
                DONE: begin
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Register bits above the used address/length fields are ignored.
    logic unused_bits;
    assign unused_bits = ^{a_base_addr_i[DWidth-1:BUF_AW], w_base_addr_i[DWidth-1:BUF_AW],
                           o_base_addr_i[DWidth-1:BUF_AW], a_num_rows_i[DWidth-1:K_CNT_W],
                           w_num_cols_i[DWidth-1:K_CNT_W], cnt_count};

endmodule

// File: tb/tb_npu_os_tile_ctrl.sv
module tb_npu_os_tile_ctrl;

    localparam int DIM = 16;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int RW  = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] a_base_addr_i = '0, a_num_rows_i = '0, w_base_addr_i = '0;
    logic [DW-1:0] w_num_cols_i = '0, o_base_addr_i = '0;
    logic          abuf_ren_o, wbuf_ren_o, pe_clear_o, pe_valid_o, drain_en_o;
    logic          obuf_wen_o, busy_o, done_o, err_o;
    logic [AW-1:0] abuf_raddr_o, wbuf_raddr_o, obuf_waddr_o;
    logic [RW-1:0] drain_row_o;

    always #5 clk_i = ~clk_i;

    npu_os_tile_ctrl #(.ARRAY_DIM(DIM), .BUF_AW(AW), .DWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .a_base_addr_i(a_base_addr_i), .a_num_rows_i(a_num_rows_i),
        .w_base_addr_i(w_base_addr_i), .w_num_cols_i(w_num_cols_i),
        .o_base_addr_i(o_base_addr_i),
        .abuf_ren_o(abuf_ren_o), .abuf_raddr_o(abuf_raddr_o),
        .wbuf_ren_o(wbuf_ren_o), .wbuf_raddr_o(wbuf_raddr_o),
        .pe_clear_o(pe_clear_o), .pe_valid_o(pe_valid_o),
        .drain_en_o(drain_en_o), .drain_row_o(drain_row_o),
        .obuf_wen_o(obuf_wen_o), .obuf_waddr_o(obuf_waddr_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    // Scoreboard entries: expected cycle plus payload.
    typedef struct { int cyc; int a; int w; } rd_t;
    typedef struct { int cyc; int addr; int row; } wr_t;
    rd_t exp_rd[$];
    wr_t exp_wr[$];
    int  exp_clr[$];
    int  exp_done[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: the latest accepted tile and the err_o history.
    bit tile_valid = 0;
    int tile_s = 0;
    int tile_k = 0;
    bit err_old = 0;
    bit err_new = 0;
    int err_chg = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic bit busy_at(input int c);
        return tile_valid && c >= tile_s && c <= tile_s + tile_k + 3 * DIM;
    endfunction

    function automatic bit valid_at(input int c);
        return tile_valid && c >= tile_s + 2 && c <= tile_s + tile_k + 1;
    endfunction

    function automatic bit err_at(input int c);
        return (c >= err_chg) ? err_new : err_old;
    endfunction

    // Monitor: one check pass per cycle, 1 time unit after the rising edge.
    initial begin
        rd_t r;
        wr_t w;
        int  e;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            chk("busy", busy_o, busy_at(cyc));
            chk("err", err_o, err_at(cyc));
            chk("pe_valid", pe_valid_o, valid_at(cyc));
            if (!busy_at(cyc))
                chk("idle_outputs", {abuf_ren_o, wbuf_ren_o, obuf_wen_o, drain_en_o, pe_clear_o,
                                     done_o, abuf_raddr_o, wbuf_raddr_o, obuf_waddr_o, drain_row_o}, 0);
            if (abuf_ren_o || wbuf_ren_o) begin
                if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    r = exp_rd.pop_front();
                    $display("read  cyc=%0d a=%0d w=%0d", cyc, abuf_raddr_o, wbuf_raddr_o);
                    chk("read_cycle", cyc, r.cyc);
                    chk("ren_pair", {abuf_ren_o, wbuf_ren_o}, 3);
                    chk("abuf_raddr", abuf_raddr_o, r.a);
                    chk("wbuf_raddr", wbuf_raddr_o, r.w);
                end
            end
            if (obuf_wen_o || drain_en_o) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    $display("write cyc=%0d addr=%0d row=%0d", cyc, obuf_waddr_o, drain_row_o);
                    chk("write_cycle", cyc, w.cyc);
                    chk("wen_pair", {obuf_wen_o, drain_en_o}, 3);
                    chk("obuf_waddr", obuf_waddr_o, w.addr);
                    chk("drain_row", drain_row_o, w.row);
                end
            end
            if (pe_clear_o) begin
                if (exp_clr.size() == 0) chk("unexpected_clear", 1, 0);
                else begin
                    e = exp_clr.pop_front();
                    chk("clear_cycle", cyc, e);
                end
            end
            if (done_o) begin
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_done.pop_front();
                    $display("done  cyc=%0d", cyc);
                    chk("done_cycle", cyc, e);
                end
            end
        end
    end

    // Drive one start pulse and record what the specification predicts.
    task automatic issue(input logic [31:0] ab, input logic [31:0] ar, input logic [31:0] wb,
                         input logic [31:0] wc, input logic [31:0] ob);
        int s;
        int k;
        @(negedge clk_i);
        a_base_addr_i = ab; a_num_rows_i = ar; w_base_addr_i = wb;
        w_num_cols_i = wc; o_base_addr_i = ob;
        start_i = 1'b1;
        s = cyc + 1;
        $display("start cyc=%0d a_base=%0d rows=%0d w_base=%0d cols=%0d o_base=%0d",
                 s, ab[AW-1:0], ar[15:0], wb[AW-1:0], wc[15:0], ob[AW-1:0]);
        if (!busy_at(s - 1)) begin
            err_old = err_at(s - 1);
            err_chg = s;
            if (ar[15:0] == wc[15:0]) begin
                k = int'(ar[15:0]) + 1;
                err_new = 1'b0;
                tile_valid = 1'b1;
                tile_s = s;
                tile_k = k;
                exp_clr.push_back(s);
                for (int i = 0; i < k; i++)
                    exp_rd.push_back('{s + 1 + i, int'((ab + 32'(i)) & 32'h3FF),
                                       int'((wb + 32'(i)) & 32'h3FF)});
                for (int r = 0; r < DIM; r++)
                    exp_wr.push_back('{s + k + 2 * DIM + r, int'((ob + 32'(r)) & 32'h3FF), r});
                exp_done.push_back(s + k + 3 * DIM);
            end else begin
                err_new = 1'b1;
            end
        end
        @(negedge clk_i);
        start_i = 1'b0;
        // Parameters must not matter after the start edge.
        a_base_addr_i = $urandom; a_num_rows_i = $urandom; w_base_addr_i = $urandom;
        w_num_cols_i = $urandom; o_base_addr_i = $urandom;
    endtask

    // Wait (bounded by the model, not the DUT) until the last tile is over.
    task automatic wait_idle();
        int guard = 0;
        @(negedge clk_i);
        while (tile_valid && cyc <= tile_s + tile_k + 3 * DIM + 1 && guard < 20000) begin
            @(negedge clk_i);
            guard++;
        end
    endtask

    task automatic reset_mid();
        @(negedge clk_i);
        rst_ni = 1'b0;
        exp_rd.delete(); exp_wr.delete(); exp_clr.delete(); exp_done.delete();
        tile_valid = 1'b0; err_old = 1'b0; err_new = 1'b0; err_chg = 0;
        #1;
        $display("reset cyc=%0d", cyc);
        chk("async_reset_outputs", {abuf_ren_o, wbuf_ren_o, obuf_wen_o, drain_en_o, pe_clear_o,
                                    pe_valid_o, busy_o, done_o, err_o, abuf_raddr_o,
                                    wbuf_raddr_o, obuf_waddr_o, drain_row_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rnd, rnd2, km1, cols;
        #1;
        chk("reset_state", {abuf_ren_o, wbuf_ren_o, obuf_wen_o, drain_en_o, pe_clear_o,
                            pe_valid_o, busy_o, done_o, err_o, abuf_raddr_o,
                            wbuf_raddr_o, obuf_waddr_o, drain_row_o}, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: basic 16-deep tile from address 0.
        issue(0, 15, 0, 15, 0);
        wait_idle();
        // 2: K=1.
        issue(5, 0, 9, 0, 3);
        wait_idle();
        // 3: address wrap on A, W and O.
        issue(1020, 7, 1022, 7, 1018);
        wait_idle();
        // 4: K mismatch, then a matched start clears err_o.
        issue(0, 15, 0, 14, 0);
        repeat (4) @(negedge clk_i);
        issue(12, 3, 40, 3, 100);
        wait_idle();
        // 5: restart attempts during FEED are ignored.
        issue(0, 15, 0, 15, 0);
        repeat (3) @(negedge clk_i);
        issue(500, 15, 600, 15, 700);
        issue(0, 15, 0, 14, 0);
        wait_idle();
        // 6: reset in the middle of DRAIN, then a fresh tile.
        issue(0, 15, 0, 15, 0);
        repeat (16 + 2 * DIM + 5) @(negedge clk_i);
        reset_mid();
        issue(33, 15, 44, 15, 55);
        wait_idle();

        // Randomized tiles, occasional mismatches and mid-tile starts.
        for (int t = 0; t < 10; t++) begin
            rnd  = $urandom;
            rnd2 = $urandom;
            km1  = 32'($urandom_range(0, 40));
            cols = ($urandom_range(0, 3) == 0) ? km1 + 1 : km1;
            issue($urandom, {rnd[31:16], km1[15:0]}, $urandom, {rnd2[31:16], cols[15:0]},
                  $urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) @(negedge clk_i);
                issue($urandom, km1, $urandom, km1, $urandom);
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end

        repeat (3) @(negedge clk_i);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("clr_queue_empty", exp_clr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
